// File: rtl/pool_pkg.sv
// Shared types and window-slot indices for the 2x2 pooling interface.
// Both the window generator and the pooling stage import this package.
package pool_pkg;

    localparam int PIX_W = 16;

    typedef logic signed [PIX_W-1:0] pix_t;

    // Slot positions inside one 2x2 window
    localparam logic [1:0] WIN_TL = 2'd0;
    localparam logic [1:0] WIN_TR = 2'd1;
    localparam logic [1:0] WIN_BL = 2'd2;
    localparam logic [1:0] WIN_BR = 2'd3;

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel-stream in / 2x2-window out bundle of the pooling window generator.
// master: the window generator (consumes pixels, produces windows).
// slave : the surrounding logic (supplies pixels, consumes windows).
// Optional build macro WIN_FRAME_SYNC_EN adds the frame_start input.
interface pool_window_gen_if
    import pool_pkg::*;
#(
    parameter int FM_DEPTH = 64
);
    logic pix_valid;
    pix_t pix_in  [FM_DEPTH];
    logic win_valid;
    pix_t win_out [FM_DEPTH][4];
    logic frame_done;

`ifdef WIN_FRAME_SYNC_EN
    logic frame_start;

    modport master (
        input  pix_valid, pix_in, frame_start,
        output win_valid, win_out, frame_done
    );
    modport slave (
        output pix_valid, pix_in, frame_start,
        input  win_valid, win_out, frame_done
    );
`else
    modport master (
        input  pix_valid, pix_in,
        output win_valid, win_out, frame_done
    );
    modport slave (
        output pix_valid, pix_in,
        input  win_valid, win_out, frame_done
    );
`endif

endinterface

// File: rtl/pool_line_buf.sv
// One-row line buffer: one write port, two combinational read ports.
// Kept as its own block so a register array can be swapped for an SRAM macro.
// Contents are deliberately not reset; every entry is rewritten on an even
// row before an odd row reads it.
module pool_line_buf #(
    parameter int NUM_ENTRIES = 8,
    parameter int ENTRY_W     = 1024,
    parameter int AW          = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr_a,
    output logic [ENTRY_W-1:0] rdata_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [ENTRY_W-1:0] rdata_b
);

    logic [ENTRY_W-1:0] mem_r [NUM_ENTRIES];

    // Store one even-row pixel vector per column
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_r[raddr_a];
    assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/pool_window_gen.sv
// pool_window_gen: turns a raster-order pixel stream into non-overlapping
// 2x2 windows (stride 2) for the average-pooling stage.
// Even rows fill the line buffer, odd/even-column pixels land in a hold
// register, and each odd/odd pixel completes a window registered on the
// next cycle. No backpressure: pix_valid=0 freezes the position counters.
// Build macro WIN_FRAME_SYNC_EN: frame_start with pix_valid forces the pixel
// to position (0,0), discarding any partial window.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int FM_DEPTH  = 64,
    parameter int FM_WIDTH  = 8,
    parameter int FM_HEIGHT = 8
) (
    input logic              clk,
    input logic              rstn,
    pool_window_gen_if.master bus
);

    localparam int CW = (FM_WIDTH  > 2) ? $clog2(FM_WIDTH)  : 1;
    localparam int RW = (FM_HEIGHT > 2) ? $clog2(FM_HEIGHT) : 1;
    localparam int LW = FM_DEPTH * PIX_W;

    localparam logic [CW-1:0] COL_LAST = CW'(FM_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FM_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    if ((FM_WIDTH < 2) || ((FM_WIDTH % 2) != 0)) begin : g_bad_width
        $error("pool_window_gen: FM_WIDTH must be even and >= 2");
    end
    if ((FM_HEIGHT < 2) || ((FM_HEIGHT % 2) != 0)) begin : g_bad_height
        $error("pool_window_gen: FM_HEIGHT must be even and >= 2");
    end

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] col_s;
    logic [RW-1:0] row_s;
    logic          sync_s;
    logic          lb_we_s;
    logic [CW-1:0] rd_left_s;
    logic [CW-1:0] rd_right_s;
    logic [LW-1:0] pix_flat_s;
    logic [LW-1:0] rd_tl_s;
    logic [LW-1:0] rd_tr_s;
    pix_t          hold_r    [FM_DEPTH];
    pix_t          win_out_r [FM_DEPTH][4];
    logic          win_valid_r;
    logic          frame_done_r;

`ifdef WIN_FRAME_SYNC_EN
    assign sync_s = bus.frame_start & bus.pix_valid;
`else
    assign sync_s = 1'b0;
`endif

    // Effective raster position of the incoming pixel (frame sync overrides counters)
    always_comb begin
        col_s = col_r;
        row_s = row_r;
        if (sync_s) begin
            col_s = '0;
            row_s = '0;
        end else begin
            col_s = col_r;
            row_s = row_r;
        end
    end

    // Line-buffer control: write on even rows, read the column pair of the current quad
    always_comb begin
        lb_we_s    = bus.pix_valid & ~row_s[0];
        rd_left_s  = col_s & ~COL_ONE;
        rd_right_s = col_s | COL_ONE;
    end

    // Pack the per-channel pixel vector into one line-buffer word
    always_comb begin
        pix_flat_s = '0;
        for (int c = 0; c < FM_DEPTH; c++) begin
            pix_flat_s[c*PIX_W +: PIX_W] = bus.pix_in[c];
        end
    end

    pool_line_buf #(
        .NUM_ENTRIES (FM_WIDTH),
        .ENTRY_W     (LW),
        .AW          (CW)
    ) u_line_buf (
        .clk     (clk),
        .we      (lb_we_s),
        .waddr   (col_s),
        .wdata   (pix_flat_s),
        .raddr_a (rd_left_s),
        .rdata_a (rd_tl_s),
        .raddr_b (rd_right_s),
        .rdata_b (rd_tr_s)
    );

    // Position counters, bottom-left hold register, window registers and strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_r        <= '0;
            row_r        <= '0;
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            for (int c = 0; c < FM_DEPTH; c++) begin
                hold_r[c] <= '0;
                for (int k = 0; k < 4; k++) begin
                    win_out_r[c][k] <= '0;
                end
            end
        end else begin
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            if (bus.pix_valid) begin
                if (col_s == COL_LAST) begin
                    col_r <= '0;
                    row_r <= (row_s == ROW_LAST) ? '0 : (row_s + ROW_ONE);
                end else begin
                    col_r <= col_s + COL_ONE;
                    row_r <= row_s;
                end
                if (row_s[0] && !col_s[0]) begin
                    for (int c = 0; c < FM_DEPTH; c++) begin
                        hold_r[c] <= bus.pix_in[c];
                    end
                end else if (row_s[0] && col_s[0]) begin
                    for (int c = 0; c < FM_DEPTH; c++) begin
                        win_out_r[c][WIN_TL] <= pix_t'(rd_tl_s[c*PIX_W +: PIX_W]);
                        win_out_r[c][WIN_TR] <= pix_t'(rd_tr_s[c*PIX_W +: PIX_W]);
                        win_out_r[c][WIN_BL] <= hold_r[c];
                        win_out_r[c][WIN_BR] <= bus.pix_in[c];
                    end
                    win_valid_r  <= 1'b1;
                    frame_done_r <= (row_s == ROW_LAST) && (col_s == COL_LAST);
                end
            end
        end
    end

    assign bus.win_valid  = win_valid_r;
    assign bus.frame_done = frame_done_r;
    assign bus.win_out    = win_out_r;

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed testbench for pool_window_gen on a 4x4 frame with 4 channels.
// Compile with +define+WIN_FRAME_SYNC_EN to also exercise frame_start.
module tb_pool_window_gen;
    import pool_pkg::*;

    localparam int D = 4;
    localparam int W = 4;
    localparam int H = 4;

    logic clk;
    logic rstn;
    int   compared;
    int   mismatched;
    int   fd_cnt;
    pix_t last_br;

    pool_window_gen_if #(.FM_DEPTH(D)) bus ();

    pool_window_gen #(
        .FM_DEPTH  (D),
        .FM_WIDTH  (W),
        .FM_HEIGHT (H)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel value generator for the test patterns
    function automatic pix_t pv(input int mode, input int r, input int c, input int ch);
        case (mode)
            0:       return pix_t'(16 * r + c + ch);
            1:       return (((r * W + c + ch) % 2) == 0) ? pix_t'(-32768) : pix_t'(32767);
            2:       return pix_t'(16 * r + c + ch + 200);
            3:       return pix_t'(-(16 * r + c + ch) - 1);
            default: return pix_t'(0);
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_win_valid"}, {31'd0, bus.win_valid}, 32'sd0);
        chk({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'sd0);
        for (int ch = 0; ch < D; ch++) begin
            for (int k = 0; k < 4; k++) begin
                chk({tag, "_win_out"}, bus.win_out[ch][k], 32'sd0);
            end
        end
    endtask

    // One clock: drive pixel at logical (r,c), then check the outputs 1 time unit after the edge
    task automatic cycle(input logic v, input int r, input int c, input int mode, input logic fs);
        logic ev;
        logic ef;
        @(negedge clk);
        bus.pix_valid = v;
        for (int ch = 0; ch < D; ch++) begin
            bus.pix_in[ch] = pv(mode, r, c, ch);
        end
`ifdef WIN_FRAME_SYNC_EN
        bus.frame_start = fs;
`else
        if (fs) begin
            $display("note: frame_start not built in");
        end
`endif
        @(posedge clk);
        #1;
        ev = v && ((r % 2) == 1) && ((c % 2) == 1);
        ef = ev && (r == H - 1) && (c == W - 1);
        chk("win_valid", {31'd0, bus.win_valid}, {31'd0, ev});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, ef});
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
        end
        if (ev) begin
            for (int ch = 0; ch < D; ch++) begin
                chk("win_tl", bus.win_out[ch][WIN_TL], pv(mode, r - 1, c - 1, ch));
                chk("win_tr", bus.win_out[ch][WIN_TR], pv(mode, r - 1, c, ch));
                chk("win_bl", bus.win_out[ch][WIN_BL], pv(mode, r, c - 1, ch));
                chk("win_br", bus.win_out[ch][WIN_BR], pv(mode, r, c, ch));
            end
            last_br = pv(mode, r, c, 0);
        end else if (!v) begin
            chk("win_hold", bus.win_out[0][WIN_BR], last_br);
        end
    endtask

    task automatic frame(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cycle(1'b1, r, c, mode, 1'b0);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        fd_cnt     = 0;
        last_br    = '0;
        rstn       = 1'b0;
        bus.pix_valid = 1'b0;
        for (int ch = 0; ch < D; ch++) begin
            bus.pix_in[ch] = '0;
        end
`ifdef WIN_FRAME_SYNC_EN
        bus.frame_start = 1'b0;
`endif

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");

        // Mid-stream reset: two windows out, then reset partway through row 2
        @(negedge clk);
        rstn = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < W; c++) begin
                cycle(1'b1, r, c, 0, 1'b0);
            end
        end
        cycle(1'b1, 2, 0, 0, 1'b0);
        cycle(1'b1, 2, 1, 0, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        bus.pix_valid = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_low");
        @(negedge clk);
        rstn = 1'b1;
        bus.pix_valid = 1'b0;
        last_br = '0;
        @(posedge clk);
        #1;
        check_zero("rst_after");

        // Continuous frame: counters restart at (0,0)
        fd_cnt = 0;
        frame(0);
        chk("fd_count_frame", fd_cnt, 32'sd1);

        // Same frame with valid gaps; windows identical, no strobe during gaps
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cycle(1'b1, r, c, 0, 1'b0);
                if (((r * W + c) % 3) == 0) begin
                    cycle(1'b0, 0, 0, 0, 1'b0);
                end
                if (((r * W + c) % 5) == 1) begin
                    cycle(1'b0, 0, 0, 0, 1'b0);
                    cycle(1'b0, 0, 0, 0, 1'b0);
                end
            end
        end

        // Signed extremes pass bit-exact
        frame(1);

        // Two back-to-back frames with distinct data
        fd_cnt = 0;
        frame(2);
        frame(3);
        chk("fd_count_two", fd_cnt, 32'sd2);

`ifdef WIN_FRAME_SYNC_EN
        // Partial frame, then frame_start at pixel (1,2) begins a fresh frame
        for (int c = 0; c < W; c++) begin
            cycle(1'b1, 0, c, 0, 1'b0);
        end
        cycle(1'b1, 1, 0, 0, 1'b0);
        cycle(1'b1, 1, 1, 0, 1'b0);
        fd_cnt = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cycle(1'b1, r, c, 3, ((r == 0) && (c == 0)) ? 1'b1 : 1'b0);
            end
        end
        chk("fd_count_sync", fd_cnt, 32'sd1);
`endif

        cycle(1'b0, 0, 0, 0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
